// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile
//
// Integer register file for the decode/execute stage. Holds 2**REG_BUS_WIDTH
// general-purpose registers of DATA_WIDTH bits. Two combinational read ports
// and one synchronous write port. Register x0 is hardwired to zero.
//
// Parameters
//   DATA_WIDTH     register width in bits (default 32)
//   REG_BUS_WIDTH  address width; register count is 2**REG_BUS_WIDTH
//
// Ports
//   clk           clock; writes commit on its rising edge
//   rst_n         asynchronous active-low reset; clears every register
//   rs1, rs2      read addresses
//   rs1_data      contents of register rs1 (0 when rs1 == 0)
//   rs2_data      contents of register rs2 (0 when rs2 == 0)
//   write_enable  commit rd_data to rd at the next rising clk
//   rd            write address
//   rd_data       write data
// -----------------------------------------------------------------------------
module regfile #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_BUS_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [REG_BUS_WIDTH-1:0] rs1,
  input  logic [REG_BUS_WIDTH-1:0] rs2,
  output logic [DATA_WIDTH-1:0]    rs1_data,
  output logic [DATA_WIDTH-1:0]    rs2_data,
  input  logic                     write_enable,
  input  logic [REG_BUS_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0]    rd_data
);

  localparam int NUM_REGS = 2 ** REG_BUS_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Writes to x0 are dropped here so regs[0] stays at its reset value; the
  // read muxes additionally force x0 to zero so no path can ever expose it.
  logic do_write;
  assign do_write = write_enable && (rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (do_write) begin
      regs[rd] <= rd_data;
    end
  end

  // Read ports are pure combinational lookups with no write-to-read bypass:
  // a value being written becomes visible only after the committing edge.
  always_comb begin
    rs1_data = '0;
    if (rs1 != '0) begin
      rs1_data = regs[rs1];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2 != '0) begin
      rs2_data = regs[rs2];
    end
  end

endmodule

// File: tb/tb_regfile.sv
// -----------------------------------------------------------------------------
// tb_regfile
//
// Self-checking bench for regfile. Stimulus pushes expected read values into a
// scoreboard queue and signals the monitor, which samples the read ports and
// compares independently of the stimulus process.
// -----------------------------------------------------------------------------
module tb_regfile;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic          write_enable;
  logic [AW-1:0] rd;
  logic [DW-1:0] rd_data;

  regfile #(
    .DATA_WIDTH   (DW),
    .REG_BUS_WIDTH(AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .write_enable(write_enable),
    .rd          (rd),
    .rd_data     (rd_data)
  );

  // 20 ns period: rising edges at 10, 30, ...; inputs change on falling edges.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    int          port;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  event        chk_ev;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [32];

  // Monitor: drains the scoreboard whenever stimulus presents a read.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = (e.port == 1) ? rs1_data : rs2_data;
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s (rs%0d): got %h required %h", e.tag, e.port, act, e.exp);
        end
      end
    end
  end

  task automatic expect_rd(input int port, input logic [31:0] exp, input string tag);
    sb.push_back('{port, exp, tag});
    ->chk_ev;
    #1;
  endtask

  task automatic rd_both(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [31:0] e1, input logic [31:0] e2,
                         input string tag);
    rs1 = a1;
    rs2 = a2;
    #1;
    expect_rd(1, e1, tag);
    expect_rd(2, e2, tag);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    rd           = a;
    rd_data      = d;
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
    if (a != 0) model[a] = d;
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 32; a++) begin
      rd_both(AW'(a), AW'(31 - a), model[a], model[31 - a], tag);
    end
  endtask

  // Directed write table: address and data chosen by hand; x0 entries must
  // read back 0, repeated addresses exercise overwrite.
  logic [AW-1:0] tbl_a [10] = '{5'd1, 5'd0, 5'd31, 5'd12, 5'd5,
                                5'd20, 5'd0, 5'd17, 5'd31, 5'd2};
  logic [31:0]   tbl_d [10] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000,
                                32'h1234_ABCD, 32'h0BAD_F00D, 32'h5555_AAAA,
                                32'h7777_7777, 32'hFEDC_BA98, 32'h0000_FFFF,
                                32'hC0DE_C0DE};
  logic [31:0]   tbl_e [10] = '{32'h0000_0001, 32'h0000_0000, 32'h8000_0000,
                                32'h1234_ABCD, 32'h0BAD_F00D, 32'h5555_AAAA,
                                32'h0000_0000, 32'hFEDC_BA98, 32'h0000_FFFF,
                                32'hC0DE_C0DE};

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst_n        = 1'b0;
    rs1          = '0;
    rs2          = '0;
    rd           = 5'd9;
    rd_data      = 32'hFFFF_FFFF;
    write_enable = 1'b1;   // must be ignored while in reset

    // Post-reset sweep
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    write_enable = 1'b0;
    rst_n        = 1'b1;
    sweep("post_reset");

    // Basic write/read
    wr(5'd5, 32'hDEAD_BEEF);
    rd_both(5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "basic_x5");
    sweep("basic_others");

    // x0 protection
    wr(5'd0, 32'hFFFF_FFFF);
    rd_both(5'd0, 5'd0, 32'h0, 32'h0, "x0_protect");

    // Directed traffic, each write followed by a read-back on rs1
    for (int i = 0; i < 10; i++) begin
      wr(tbl_a[i], tbl_d[i]);
      rs1 = tbl_a[i];
      #1;
      expect_rd(1, tbl_e[i], "traffic");
    end

    // Back-to-back writes to x10: last write wins
    @(negedge clk);
    rd = 5'd10; rd_data = 32'h1111_1111; write_enable = 1'b1;
    @(negedge clk);
    rs1 = 5'd10;
    #1;
    expect_rd(1, 32'h1111_1111, "b2b_first");
    rd_data = 32'h2222_2222;
    @(negedge clk);
    write_enable = 1'b0;
    model[10] = 32'h2222_2222;
    #1;
    expect_rd(1, 32'h2222_2222, "b2b_last");

    // No bypass and enable gating on x7
    @(negedge clk);
    rs1 = 5'd7; rd = 5'd7; rd_data = 32'h1234_5678; write_enable = 1'b1;
    #1;
    expect_rd(1, 32'h0, "no_bypass_before");
    @(posedge clk);
    #1;
    expect_rd(1, 32'h1234_5678, "no_bypass_after");
    model[7] = 32'h1234_5678;
    @(negedge clk);
    write_enable = 1'b0;
    @(negedge clk);
    rd_data = 32'hCAFE_F00D;
    @(negedge clk);
    #1;
    expect_rd(1, 32'h1234_5678, "disabled_write");

    // Async reset mid-run
    wr(5'd3, 32'hA5A5_A5A5);
    rd_both(5'd3, 5'd5, 32'hA5A5_A5A5, 32'h0BAD_F00D, "pre_async");
    @(negedge clk);
    rd = 5'd4; rd_data = 32'h4444_4444; write_enable = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    expect_rd(1, 32'h0, "async_rst_x3");
    expect_rd(2, 32'h0, "async_rst_x5");
    @(posedge clk);
    @(negedge clk);
    rst_n        = 1'b1;
    write_enable = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rd_both(5'd4, 5'd3, 32'h0, 32'h0, "write_during_rst");

    // First write after reset release
    wr(5'd3, 32'h0F0F_0F0F);
    rd_both(5'd3, 5'd3, 32'h0F0F_0F0F, 32'h0F0F_0F0F, "post_rst_write");
    sweep("final");

    #5;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
